// File: rtl/spu_pkg.sv
// spu_pkg: shared SPU front-end types and default widths
package spu_pkg;
    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_INSTR_W = 32;

    typedef logic [DEFAULT_INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } fetch_state_t;
endpackage

// File: rtl/spu_instr_ram.sv
// spu_instr_ram: instruction buffer with one write port and two registered read ports (addr, addr+1)
// Ports: clk, rst (sync active-low, clears read registers only), we/waddr/wdata write port,
//        re/raddr read request, rdata0 = mem[raddr], rdata1 = mem[raddr+1] one cycle later.
module spu_instr_ram #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata0,
    output logic [INSTR_W-1:0] rdata1
);
    logic [INSTR_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0]  raddr1;

    // wraps at the top of the buffer; the fetch unit marks that slot invalid
    assign raddr1 = raddr + 1'b1;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (re) begin
            rdata0 <= mem[raddr];
            rdata1 <= mem[raddr1];
        end
    end
endmodule

// File: rtl/spu_fetch_unit.sv
// spu_fetch_unit: dual-issue instruction fetch with local program buffer, stall, branch and end detection
// Ports: clk, rst (sync active-low); load_en/load_data sequential program load; start begins fetch at PC 0;
//        stall holds PC and outputs; branch_taken/branch_target redirect (overrides stall);
//        instr_out0/1 + valid_out0/1 issue pair at pc_out/pc_out+1; prog_len loaded count;
//        load_full buffer full; done program exhausted. All outputs registered.
module spu_fetch_unit
    import spu_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr_out0,
    output logic [INSTR_W-1:0] instr_out1,
    output logic               valid_out0,
    output logic               valid_out1,
    output logic [ADDR_W:0]    pc_out,
    output logic [ADDR_W:0]    prog_len,
    output logic               load_full,
    output logic               done
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    fetch_state_t    state;
    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] pc_inc1;
    logic [ADDR_W:0] pc_inc2;
    logic [ADDR_W:0] len_after;
    logic [ADDR_W:0] target;
    logic            do_write;
    logic            do_fetch;
    logic            target_out;

    always_comb begin
        do_write   = (state == S_IDLE || state == S_LOAD) && load_en && !load_full;
        do_fetch   = (state == S_RUN) && !stall && !branch_taken;
        len_after  = prog_len + (ADDR_W+1)'(do_write);
        pc_inc1    = pc + (ADDR_W+1)'(1);
        pc_inc2    = pc + (ADDR_W+1)'(2);
        target     = {1'b0, branch_target};
        target_out = target >= prog_len;
    end

    // the RAM read registers are the instruction outputs; disabling the read freezes them
    spu_instr_ram #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write),
        .waddr (prog_len[ADDR_W-1:0]),
        .wdata (load_data),
        .re    (do_fetch),
        .raddr (pc[ADDR_W-1:0]),
        .rdata0(instr_out0),
        .rdata1(instr_out1)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            pc_out     <= '0;
            prog_len   <= '0;
            valid_out0 <= 1'b0;
            valid_out1 <= 1'b0;
            load_full  <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (do_write) begin
                        prog_len  <= len_after;
                        load_full <= len_after == DEPTH;
                    end
                    // a load in the same cycle as start counts toward the program
                    if (start) begin
                        pc    <= '0;
                        state <= (len_after == '0) ? S_DONE : S_RUN;
                    end else if (load_en) begin
                        state <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (branch_taken) begin
                        pc         <= target;
                        valid_out0 <= 1'b0;
                        valid_out1 <= 1'b0;
                        state      <= target_out ? S_DONE : S_RUN;
                    end else if (!stall) begin
                        pc_out     <= pc;
                        valid_out0 <= pc < prog_len;
                        // at pc = DEPTH-1, pc_inc1 = DEPTH >= prog_len, so the wrapped read is never valid
                        valid_out1 <= pc_inc1 < prog_len;
                        pc         <= pc_inc2;
                        if (pc_inc2 >= prog_len) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_out0 <= 1'b0;
                    valid_out1 <= 1'b0;
                    if (branch_taken && !target_out) begin
                        pc    <= target;
                        state <= S_RUN;
                        done  <= 1'b0;
                    end else begin
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spu_fetch_unit.sv
// tb_spu_fetch_unit: directed table-driven bench for spu_fetch_unit (default and ADDR_W=3 instances)
module tb_spu_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;

    logic [31:0] i0, i1;
    logic        v0, v1;
    logic [10:0] pc, plen;
    logic        full, done;

    logic [31:0] a_i0, a_i1;
    logic        a_v0, a_v1;
    logic [3:0]  a_pc, a_plen;
    logic        a_full, a_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spu_fetch_unit dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data), .start(start),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_out0(i0), .instr_out1(i1), .valid_out0(v0), .valid_out1(v1),
        .pc_out(pc), .prog_len(plen), .load_full(full), .done(done)
    );

    spu_fetch_unit #(.ADDR_W(3), .INSTR_W(32)) dut3 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data), .start(start),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target[2:0]),
        .instr_out0(a_i0), .instr_out1(a_i1), .valid_out0(a_v0), .valid_out1(a_v1),
        .pc_out(a_pc), .prog_len(a_plen), .load_full(a_full), .done(a_done)
    );

    typedef struct {
        int load_n;
        bit st;
        bit br;
        int tgt;
        bit e0;
        bit e1;
        int x0;
        int x1;
        int p;
        bit d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ld, bit st, bit br, int tg, bit e0, bit e1,
                                int x0, int x1, int p, bit d);
        vec_t r;
        r.load_n = ld; r.st = st; r.br = br; r.tgt = tg;
        r.e0 = e0; r.e1 = e1; r.x0 = x0; r.x1 = x1; r.p = p; r.d = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        load_en = 0; load_data = '0; start = 0; stall = 0; branch_taken = 0; branch_target = '0;
    endtask

    task automatic do_reset;
        idle_in();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic load_prog(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            load_en = 1;
            load_data = 32'(base + k);
            tick();
        end
        load_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // load 6, straight run
        vecs.push_back(mk(6, 0, 0, 0, 1, 1, 'h100, 'h101, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h104, 'h105, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1));
        // load 5, odd length tail
        vecs.push_back(mk(5, 0, 0, 0, 1, 1, 'h100, 'h101, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h104, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1));
        // load 8: stall, branch, branch+stall, loop-back from DONE, out-of-range branch
        vecs.push_back(mk(8, 0, 0, 0, 1, 1, 'h100, 'h101, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 'h102, 'h103, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h104, 'h105, 4, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h101, 'h102, 1, 0));
        vecs.push_back(mk(0, 1, 1, 6, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h106, 'h107, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 6, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 'h100, 'h101, 0, 0));
        vecs.push_back(mk(0, 0, 1, 9, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // reset state
        do_reset();
        chk("rst.instr0", i0, 0);
        chk("rst.instr1", i1, 0);
        chk("rst.valid0", v0, 0);
        chk("rst.valid1", v1, 0);
        chk("rst.pc", pc, 0);
        chk("rst.prog_len", plen, 0);
        chk("rst.load_full", full, 0);
        chk("rst.done", done, 0);

        // prog_len visible the cycle after the load edge
        load_prog(1, 'h100);
        chk("load1.prog_len", plen, 1);

        foreach (vecs[n]) begin
            if (vecs[n].load_n > 0) begin
                do_reset();
                load_prog(vecs[n].load_n, 'h100);
                chk($sformatf("v%0d.prog_len", n), plen, 11'(vecs[n].load_n));
                start = 1;
                tick();
                start = 0;
            end
            stall = vecs[n].st;
            branch_taken = vecs[n].br;
            branch_target = 10'(vecs[n].tgt);
            tick();
            stall = 0;
            branch_taken = 0;
            chk($sformatf("v%0d.valid0", n), v0, vecs[n].e0);
            chk($sformatf("v%0d.valid1", n), v1, vecs[n].e1);
            chk($sformatf("v%0d.pc", n), pc, 64'(vecs[n].p));
            chk($sformatf("v%0d.done", n), done, vecs[n].d);
            if (vecs[n].e0) chk($sformatf("v%0d.instr0", n), i0, 64'(vecs[n].x0));
            if (vecs[n].e1) chk($sformatf("v%0d.instr1", n), i1, 64'(vecs[n].x1));
        end

        // load and start in the same cycle: the load counts
        do_reset();
        load_prog(2, 'h100);
        load_en = 1; load_data = 'h102; start = 1;
        tick();
        idle_in();
        chk("ls.prog_len", plen, 3);
        tick();
        chk("ls.p0.instr0", i0, 'h100);
        chk("ls.p0.instr1", i1, 'h101);
        tick();
        chk("ls.p1.valid0", v0, 1);
        chk("ls.p1.instr0", i0, 'h102);
        chk("ls.p1.valid1", v1, 0);
        tick();
        chk("ls.done", done, 1);

        // ADDR_W=3 instance: fill, overflow drop, no wrap at the end
        do_reset();
        load_prog(7, 'h200);
        chk("a.len7", a_plen, 7);
        chk("a.full7", a_full, 0);
        load_prog(2, 'h207);
        chk("a.len9", a_plen, 8);
        chk("a.full9", a_full, 1);
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("a.p%0d.instr0", k), a_i0, 64'('h200 + 2 * k));
            chk($sformatf("a.p%0d.instr1", k), a_i1, 64'('h201 + 2 * k));
            chk($sformatf("a.p%0d.pc", k), a_pc, 64'(2 * k));
            chk($sformatf("a.p%0d.valid0", k), a_v0, 1);
            chk($sformatf("a.p%0d.valid1", k), a_v1, 1);
            chk($sformatf("a.p%0d.done", k), a_done, 0);
        end
        tick();
        chk("a.end.done", a_done, 1);
        chk("a.end.valid0", a_v0, 0);
        chk("a.end.valid1", a_v1, 0);

        // reset mid-RUN, then start with nothing loaded
        do_reset();
        load_prog(4, 'h100);
        start = 1;
        tick();
        start = 0;
        tick();
        chk("mr.pre.valid0", v0, 1);
        rst = 0;
        tick();
        rst = 1;
        chk("mr.instr0", i0, 0);
        chk("mr.instr1", i1, 0);
        chk("mr.valid0", v0, 0);
        chk("mr.valid1", v1, 0);
        chk("mr.pc", pc, 0);
        chk("mr.prog_len", plen, 0);
        chk("mr.done", done, 0);
        start = 1;
        tick();
        start = 0;
        chk("empty.done0", done, 0);
        tick();
        chk("empty.done1", done, 1);
        chk("empty.valid0", v0, 0);
        chk("empty.valid1", v1, 0);
        tick();
        chk("empty.hold.valid0", v0, 0);
        chk("empty.hold.done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
